// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm buzzer player.
//   - note codes (1..7 = C5..B5, 0 = rest)
//   - note_half(): tone half-period in clock cycles for a note code
//   - melody_note()/melody_dur(): melody ROM, indexed by step 0..7
//   - state_t: player FSM encoding
package alarm_pkg;

    localparam logic [2:0] NOTE_R  = 3'd0;
    localparam logic [2:0] NOTE_C5 = 3'd1;
    localparam logic [2:0] NOTE_D5 = 3'd2;
    localparam logic [2:0] NOTE_E5 = 3'd3;
    localparam logic [2:0] NOTE_F5 = 3'd4;
    localparam logic [2:0] NOTE_G5 = 3'd5;
    localparam logic [2:0] NOTE_A5 = 3'd6;
    localparam logic [2:0] NOTE_B5 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Half-period in clock cycles, floor(clk_hz / (2*freq)); 0 for a rest.
    function automatic logic [15:0] note_half(input int clk_hz, input logic [2:0] note);
        int hz;
        case (note)
            NOTE_C5: hz = 523;
            NOTE_D5: hz = 587;
            NOTE_E5: hz = 659;
            NOTE_F5: hz = 698;
            NOTE_G5: hz = 784;
            NOTE_A5: hz = 880;
            NOTE_B5: hz = 988;
            default: hz = 0;
        endcase
        if (hz == 0) return 16'd0;
        return 16'(clk_hz / (2 * hz));
    endfunction

    function automatic logic [2:0] melody_note(input logic [2:0] step);
        case (step)
            3'd0, 3'd2, 3'd4: return NOTE_A5;
            3'd6:             return NOTE_E5;
            default:          return NOTE_R;
        endcase
    endfunction

    // Duration in 125 ms units.
    function automatic logic [3:0] melody_dur(input logic [2:0] step);
        case (step)
            3'd6, 3'd7: return 4'd2;
            default:    return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/alarm_player_tone_gen.sv
// tone_gen: square-wave divider for the piezo.
//   newclk  in   clock
//   rst_n   in   asynchronous active-low reset
//   en      in   count enable
//   clr     in   synchronous clear of counter and output (takes priority)
//   half    in   half-period in cycles; 0 holds the output low
//   sq      out  registered square wave, toggles when the counter hits half-1
module tone_gen
    import alarm_pkg::*;
(
    input  logic        newclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] half,
    output logic        sq
);

    logic [15:0] cnt;

    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
            sq  <= 1'b0;
        end else if (clr) begin
            cnt <= 16'd0;
            sq  <= 1'b0;
        end else if (en && half != 16'd0) begin
            if (cnt == half - 16'd1) begin
                cnt <= 16'd0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_player.sv
// alarm_player: plays the ROM melody on the piezo when the alarm fires.
//   newclk    in   clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   alarm_do  in   alarm-hit level ("do" of the alarm block; renamed since
//                  "do" is a reserved word); rising edge starts playback
//   middle    in   stop button level; rising edge silences playback
//   buzzer    out  registered square-wave drive to the piezo
//   playing   out  high while in PLAY
//   step      out  current melody step 0..7
//   done      out  one-cycle pulse on entry to DONE
module alarm_player
    import alarm_pkg::*;
#(
    parameter int CLK_HZ      = 1_000_000,
    parameter int STEP_CYCLES = CLK_HZ / 8,
    parameter int REPEATS     = 4
) (
    input  logic       newclk,
    input  logic       rst_n,
    input  logic       alarm_do,
    input  logic       middle,
    output logic       buzzer,
    output logic       playing,
    output logic [2:0] step,
    output logic       done
);

    localparam int TW = $clog2(8 * STEP_CYCLES + 1);
    localparam int LW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    state_t          state, state_nx;
    logic            do_q, mid_q;
    logic            trig, stp;
    logic [TW-1:0]   timer;
    logic [LW-1:0]   loop;
    logic            tc, last_loop;
    logic [2:0]      note;
    logic [15:0]     half;
    logic            tone_clr, tone_en;

    always_comb begin
        trig      = alarm_do & ~do_q;
        stp       = middle & ~mid_q;
        note      = melody_note(step);
        half      = note_half(CLK_HZ, note);
        tc        = (timer == TW'(STEP_CYCLES * int'(melody_dur(step)) - 1));
        last_loop = (loop == LW'(REPEATS - 1));

        state_nx = state;
        case (state)
            IDLE: if (trig) state_nx = stp ? DONE : PLAY;
            PLAY: begin
                if (stp)
                    state_nx = DONE;
                else if (tc && step == 3'd7 && last_loop)
                    state_nx = DONE;
            end
            DONE: if (!alarm_do) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Clearing on every step change (and on entry to PLAY) makes each
        // note start low with a fresh half-period; rests hold the divider at 0.
        tone_en  = (state == PLAY);
        tone_clr = (state != PLAY) || stp || tc || (note == NOTE_R);
    end

    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) begin
            do_q  <= 1'b0;
            mid_q <= 1'b0;
            step  <= 3'd0;
            loop  <= '0;
            timer <= '0;
            done  <= 1'b0;
        end else begin
            do_q  <= alarm_do;
            mid_q <= middle;
            done  <= (state_nx == DONE) && (state != DONE);
            case (state)
                IDLE: begin
                    if (trig && !stp) begin
                        step  <= 3'd0;
                        loop  <= '0;
                        timer <= '0;
                    end
                end
                PLAY: begin
                    // A stop freezes everything; DONE ignores these registers.
                    if (!stp) begin
                        if (tc) begin
                            timer <= '0;
                            if (step != 3'd7) begin
                                step <= step + 3'd1;
                            end else if (!last_loop) begin
                                step <= 3'd0;
                                loop <= loop + LW'(1);
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign playing = (state == PLAY);

    tone_gen u_tone (
        .newclk (newclk),
        .rst_n  (rst_n),
        .en     (tone_en),
        .clr    (tone_clr),
        .half   (half),
        .sq     (buzzer)
    );

endmodule

// File: tb/tb_alarm_player.sv
module tb_alarm_player;

    localparam int CLK_HZ      = 1_000_000;
    localparam int STEP_CYCLES = 1000;
    localparam int REPEATS     = 2;
    localparam int LOOP_CYC    = 10 * STEP_CYCLES;

    logic       newclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       alarm_do = 1'b0;
    logic       middle = 1'b0;
    logic       buzzer, playing, done;
    logic [2:0] step;

    int total = 0;
    int bad   = 0;

    int note_hz[8] = '{880, 0, 880, 0, 880, 0, 659, 0};
    int dur_u[8]   = '{1, 1, 1, 1, 1, 1, 2, 2};

    always #5 newclk = ~newclk;

    alarm_player #(
        .CLK_HZ      (CLK_HZ),
        .STEP_CYCLES (STEP_CYCLES),
        .REPEATS     (REPEATS)
    ) dut (
        .newclk   (newclk),
        .rst_n    (rst_n),
        .alarm_do (alarm_do),
        .middle   (middle),
        .buzzer   (buzzer),
        .playing  (playing),
        .step     (step),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected step and buzzer level k cycles into playback (k=0 is the
    // first PLAY cycle), from the melody table and the tone rule.
    function automatic void model(input int k, output int s, output int b);
        int u, off, half;
        u   = k % LOOP_CYC;
        s   = 0;
        off = 0;
        for (int i = 0; i < 8; i++) begin
            if (u < dur_u[i] * STEP_CYCLES) begin
                s   = i;
                off = u;
                break;
            end
            u -= dur_u[i] * STEP_CYCLES;
        end
        half = (note_hz[s] == 0) ? 0 : CLK_HZ / (2 * note_hz[s]);
        b    = (half == 0) ? 0 : (off / half) % 2;
    endfunction

    task automatic check_play(input int k0, input int k1);
        int s, b;
        for (int k = k0; k <= k1; k++) begin
            @(negedge newclk);
            model(k, s, b);
            chk("play_step", 32'(step), s);
            chk("play_buzzer", 32'(buzzer), b);
            chk("play_playing", 32'(playing), 1);
            chk("play_done", 32'(done), 0);
        end
    endtask

    task automatic check_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge newclk);
            chk("quiet_playing", 32'(playing), 0);
            chk("quiet_buzzer", 32'(buzzer), 0);
            chk("quiet_done", 32'(done), 0);
        end
    endtask

    task automatic check_done_entry(input string tag);
        @(negedge newclk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_playing"}, 32'(playing), 0);
        chk({tag, "_buzzer"}, 32'(buzzer), 0);
    endtask

    initial begin
        int stopk, k;

        // Reset state
        repeat (2) @(negedge newclk);
        chk("rst_buzzer", 32'(buzzer), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        check_quiet(3 + int'($urandom_range(0, 5)));

        // Full playback: tones, rests, loop wrap, auto-stop
        alarm_do = 1'b1;
        check_play(0, REPEATS * LOOP_CYC - 1);
        check_done_entry("auto");
        // do held high: no restart
        check_quiet(int'($urandom_range(50, 300)));

        // Re-arm, then user stop somewhere inside step 2
        alarm_do = 1'b0;
        check_quiet(int'($urandom_range(1, 5)));
        alarm_do = 1'b1;
        stopk = 2 * STEP_CYCLES + int'($urandom_range(0, STEP_CYCLES - 1));
        check_play(0, stopk);
        middle = 1'b1;
        check_done_entry("stop");
        check_quiet(int'($urandom_range(20, 100)));

        // Trigger and stop in the same cycle from IDLE
        alarm_do = 1'b0;
        middle   = 1'b0;
        check_quiet(2);
        alarm_do = 1'b1;
        middle   = 1'b1;
        check_done_entry("both");
        check_quiet(50);

        // Asynchronous reset while a note is sounding
        alarm_do = 1'b0;
        middle   = 1'b0;
        check_quiet(2);
        alarm_do = 1'b1;
        k = 568 + int'($urandom_range(0, 400));
        check_play(0, k);
        #2;
        rst_n    = 1'b0;
        alarm_do = 1'b0;
        #1;
        chk("arst_buzzer", 32'(buzzer), 0);
        chk("arst_playing", 32'(playing), 0);
        chk("arst_step", 32'(step), 0);
        chk("arst_done", 32'(done), 0);
        repeat (2) @(negedge newclk);
        rst_n = 1'b1;
        check_quiet(int'($urandom_range(10, 50)));
        alarm_do = 1'b1;
        check_play(0, 1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
